// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine: FSM state encoding and the
// width-agnostic CRC step, which operates on MSB-aligned 32-bit words.
package crc_pkg;

    localparam int CRC_MAX_W = 32;

    typedef logic [CRC_MAX_W-1:0] crc_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Left-align a narrow value so that its MSB sits at bit CRC_MAX_W-1.
    function automatic crc_word_t crc_align(input crc_word_t value, input int width);
        return value << (CRC_MAX_W - width);
    endfunction

    // One MSB-first LFSR step; crc and poly must both be left-aligned.
    function automatic crc_word_t crc_step(input crc_word_t crc, input logic bit_in,
                                           input crc_word_t poly);
        logic fb_s;
        fb_s = bit_in ^ crc[CRC_MAX_W-1];
        if (fb_s) begin
            return {crc[CRC_MAX_W-2:0], 1'b0} ^ poly;
        end else begin
            return {crc[CRC_MAX_W-2:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/crc_lfsr.sv
// CRC shift register: load has priority over a step, otherwise the value holds.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int              WIDTH = 6,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(6'h03)
) (
    input  logic             mainclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             bit_in,
    output logic [WIDTH-1:0] state_out
);

    localparam crc_word_t POLY_AL = crc_align(crc_word_t'(POLY), WIDTH);

    logic [WIDTH-1:0] crc_r;
    logic [WIDTH-1:0] crc_nx_s;

    // Next register value: reload, step or hold.
    always_comb begin
        crc_nx_s = crc_r;
        if (load) begin
            crc_nx_s = load_value;
        end else if (enable) begin
            crc_nx_s = WIDTH'(crc_step(crc_align(crc_word_t'(crc_r), WIDTH), bit_in, POLY_AL)
                              >> (CRC_MAX_W - WIDTH));
        end else begin
            crc_nx_s = crc_r;
        end
    end

    // CRC state register.
    always_ff @(posedge mainclk) begin
        if (reset) begin
            crc_r <= {WIDTH{1'b0}};
        end else begin
            crc_r <= crc_nx_s;
        end
    end

    assign state_out = crc_r;

endmodule

// File: rtl/crc_lfsr_engine.sv
// Serial CRC generator/checker: accepts MSB-first message bits, then either
// shifts the CRC out serially (generate) or reports a zero residue (check).
module crc_lfsr_engine
    import crc_pkg::*;
#(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(6'h03),
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1'b0)
) (
    input  logic             mainclk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             last,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] crc_out,
    output logic             crc_valid,
    output logic             match
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam crc_word_t        POLY_AL  = crc_align(crc_word_t'(POLY), WIDTH);

    state_t           state_r, state_nx_s;
    logic             mode_r, mode_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [CNT_W-1:0] ser_idx_s;
    logic [WIDTH-1:0] crc_s, crc_upd_s;
    logic [WIDTH-1:0] crc_out_r, crc_out_nx_s;
    logic             match_r, match_nx_s;
    logic             ser_out_nx_s;
    logic             lfsr_en_s, lfsr_ld_s;
    logic             ready_r, busy_r, ser_out_r, ser_valid_r, crc_valid_r;

    crc_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_crc_lfsr (
        .mainclk    (mainclk),
        .reset      (reset),
        .enable     (lfsr_en_s),
        .load       (lfsr_ld_s),
        .load_value (INIT),
        .bit_in     (bit_in),
        .state_out  (crc_s)
    );

    // The final CRC must be captured in the same cycle the last bit is accepted.
    assign crc_upd_s = WIDTH'(crc_step(crc_align(crc_word_t'(crc_s), WIDTH), bit_in, POLY_AL)
                              >> (CRC_MAX_W - WIDTH));

    // Next-state, LFSR control and next output values.
    always_comb begin
        state_nx_s   = state_r;
        mode_nx_s    = mode_r;
        cnt_nx_s     = cnt_r;
        crc_out_nx_s = crc_out_r;
        match_nx_s   = match_r;
        lfsr_en_s    = 1'b0;
        lfsr_ld_s    = 1'b0;
        ser_out_nx_s = 1'b0;
        ser_idx_s    = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    lfsr_ld_s  = 1'b1;
                    mode_nx_s  = mode;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    lfsr_ld_s  = 1'b1;
                    mode_nx_s  = mode;
                    state_nx_s = ST_RUN;
                end else if (bit_valid) begin
                    lfsr_en_s = 1'b1;
                    if (last) begin
                        crc_out_nx_s = crc_upd_s;
                        cnt_nx_s     = {CNT_W{1'b0}};
                        if (mode_r) begin
                            match_nx_s = (crc_upd_s == {WIDTH{1'b0}});
                            state_nx_s = ST_DONE;
                        end else begin
                            match_nx_s = 1'b0;
                            state_nx_s = ST_EMIT;
                        end
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_EMIT: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_DONE;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    state_nx_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
        // Emit index counts down from the MSB as the counter counts up.
        if (state_nx_s == ST_EMIT) begin
            ser_idx_s    = CNT_LAST - cnt_nx_s;
            ser_out_nx_s = crc_out_nx_s[ser_idx_s];
        end else begin
            ser_out_nx_s = 1'b0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge mainclk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            crc_out_r   <= {WIDTH{1'b0}};
            match_r     <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            crc_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            mode_r      <= mode_nx_s;
            cnt_r       <= cnt_nx_s;
            crc_out_r   <= crc_out_nx_s;
            match_r     <= match_nx_s;
            ready_r     <= (state_nx_s == ST_RUN);
            busy_r      <= (state_nx_s != ST_IDLE);
            ser_out_r   <= ser_out_nx_s;
            ser_valid_r <= (state_nx_s == ST_EMIT);
            crc_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign crc_out   = crc_out_r;
    assign crc_valid = crc_valid_r;
    assign match     = match_r;

endmodule

// File: tb/tb_crc_lfsr_engine.sv
// Directed bench for crc_lfsr_engine: a WIDTH=3 instance (x^3+x+1) and a
// default-parameter instance, with hand-computed CRC values.
module tb_crc_lfsr_engine;

    logic       mainclk = 1'b0;
    logic       reset   = 1'b1;
    logic       start = 1'b0, mode = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, last = 1'b0;
    logic       ready, busy, ser_out, ser_valid, crc_valid, match;
    logic [2:0] crc_out;

    logic       d_start = 1'b0, d_mode = 1'b0, d_bit_in = 1'b0, d_bit_valid = 1'b0, d_last = 1'b0;
    logic       d_ready, d_busy, d_ser_out, d_ser_valid, d_crc_valid, d_match;
    logic [5:0] d_crc_out;

    int checks   = 0;
    int failures = 0;

    always #5 mainclk = ~mainclk;

    crc_lfsr_engine #(.WIDTH(3), .POLY(3'b011), .INIT(3'b000)) dut (
        .mainclk(mainclk), .reset(reset), .start(start), .mode(mode),
        .bit_in(bit_in), .bit_valid(bit_valid), .last(last),
        .ready(ready), .busy(busy), .ser_out(ser_out), .ser_valid(ser_valid),
        .crc_out(crc_out), .crc_valid(crc_valid), .match(match)
    );

    crc_lfsr_engine dut6 (
        .mainclk(mainclk), .reset(reset), .start(d_start), .mode(d_mode),
        .bit_in(d_bit_in), .bit_valid(d_bit_valid), .last(d_last),
        .ready(d_ready), .busy(d_busy), .ser_out(d_ser_out), .ser_valid(d_ser_valid),
        .crc_out(d_crc_out), .crc_valid(d_crc_valid), .match(d_match)
    );

    task automatic tick();
        @(posedge mainclk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic l);
        bit_valid = 1'b1;
        bit_in    = b;
        last      = l;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last      = 1'b0;
    endtask

    // Observes the generate-mode tail: WIDTH emit cycles, one DONE cycle, then idle.
    task automatic expect_emit(input string name, input logic [2:0] exp_crc, input logic hold_start);
        checks++;
        if (crc_out !== exp_crc) begin
            failures++;
            $display("FAIL %s crc_out: got %b expected %b", name, crc_out, exp_crc);
        end
        start = hold_start;
        mode  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ser_valid, ser_out, crc_valid, ready, busy} !== {1'b1, exp_crc[2-k], 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL %s emit%0d {sv,so,cv,rdy,busy}: got %b expected %b", name, k,
                         {ser_valid, ser_out, crc_valid, ready, busy},
                         {1'b1, exp_crc[2-k], 1'b0, 1'b0, 1'b1});
            end
            tick();
        end
        checks++;
        if ({ser_valid, crc_valid, busy, ready, match} !== 5'b01100) begin
            failures++;
            $display("FAIL %s done {sv,cv,busy,rdy,match}: got %b expected 01100", name,
                     {ser_valid, crc_valid, busy, ready, match});
        end
        tick();
        start = 1'b0;
        mode  = 1'b0;
        checks++;
        if ({crc_valid, busy, ready, crc_out} !== {3'b000, exp_crc}) begin
            failures++;
            $display("FAIL %s idle {cv,busy,rdy,crc}: got %b expected %b", name,
                     {crc_valid, busy, ready, crc_out}, {3'b000, exp_crc});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({ready, busy, ser_out, ser_valid, crc_valid, match, crc_out} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected 000000000",
                     {ready, busy, ser_out, ser_valid, crc_valid, match, crc_out});
        end
        reset = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        last      = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last      = 1'b0;
        checks++;
        if ({ready, busy, crc_valid, ser_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ignores_bits: got %b expected 0000", {ready, busy, crc_valid, ser_valid});
        end
    endtask

    task automatic test_generate();
        logic [3:0] msg;
        msg = 4'b1101;
        do_start(1'b0);
        checks++;
        if ({ready, busy} !== 2'b11) begin
            failures++;
            $display("FAIL gen_run_flags: got %b expected 11", {ready, busy});
        end
        for (int i = 3; i >= 0; i--) send_bit(msg[i], (i == 0));
        expect_emit("gen_1101", 3'b001, 1'b0);
    endtask

    task automatic test_check();
        logic [6:0] msg;
        msg = 7'b1101001;
        do_start(1'b1);
        for (int i = 6; i >= 0; i--) send_bit(msg[i], (i == 0));
        checks++;
        if ({crc_valid, match, ser_valid, busy, crc_out} !== {4'b1101, 3'b000}) begin
            failures++;
            $display("FAIL chk_good {cv,match,sv,busy,crc}: got %b expected 1101000",
                     {crc_valid, match, ser_valid, busy, crc_out});
        end
        tick();
        checks++;
        if ({crc_valid, match, busy, crc_out} !== {3'b010, 3'b000}) begin
            failures++;
            $display("FAIL chk_good_hold {cv,match,busy,crc}: got %b expected 010000",
                     {crc_valid, match, busy, crc_out});
        end
        // Residue for the corrupted frame works out to x^4 mod (x^3+x+1).
        msg = 7'b1101011;
        do_start(1'b1);
        for (int i = 6; i >= 0; i--) send_bit(msg[i], (i == 0));
        checks++;
        if ({crc_valid, match, crc_out} !== {2'b10, 3'b110}) begin
            failures++;
            $display("FAIL chk_bad {cv,match,crc}: got %b expected 10110", {crc_valid, match, crc_out});
        end
        tick();
    endtask

    task automatic test_single_bit();
        do_start(1'b0);
        send_bit(1'b1, 1'b1);
        expect_emit("gen_single", 3'b011, 1'b0);
    endtask

    task automatic test_restart_gaps();
        do_start(1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        do_start(1'b0);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        send_bit(1'b1, 1'b0);
        tick();
        checks++;
        if ({ready, busy, ser_valid} !== 3'b110) begin
            failures++;
            $display("FAIL restart_gap_flags: got %b expected 110", {ready, busy, ser_valid});
        end
        send_bit(1'b1, 1'b0);
        tick();
        tick();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        expect_emit("restart_1101", 3'b001, 1'b0);
    endtask

    task automatic test_start_ignored();
        do_start(1'b0);
        send_bit(1'b1, 1'b1);
        expect_emit("start_in_emit", 3'b011, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_start(1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        checks++;
        if ({ready, busy, ser_valid, crc_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_run: got %b expected 0000", {ready, busy, ser_valid, crc_valid});
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({ready, busy} !== 2'b11) begin
            failures++;
            $display("FAIL start_after_reset: got %b expected 11", {ready, busy});
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ready, busy, ser_out, ser_valid, crc_valid, match, crc_out} !== 9'b0) begin
            failures++;
            $display("FAIL reset_mid_emit: got %b expected 000000000",
                     {ready, busy, ser_out, ser_valid, crc_valid, match, crc_out});
        end
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        last      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ready, busy, ser_valid, crc_valid, crc_out} !== 7'b0) begin
                failures++;
                $display("FAIL post_reset_ignore%0d: got %b expected 0000000", i,
                         {ready, busy, ser_valid, crc_valid, crc_out});
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last      = 1'b0;
    endtask

    task automatic test_default_params();
        logic [5:0] exp;
        exp = 6'h03;
        d_start = 1'b1;
        tick();
        d_start     = 1'b0;
        d_bit_valid = 1'b1;
        d_bit_in    = 1'b1;
        d_last      = 1'b1;
        tick();
        d_bit_valid = 1'b0;
        d_bit_in    = 1'b0;
        d_last      = 1'b0;
        checks++;
        if (d_crc_out !== exp) begin
            failures++;
            $display("FAIL w6_crc_out: got %h expected %h", d_crc_out, exp);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({d_ser_valid, d_ser_out, d_crc_valid} !== {1'b1, exp[5-k], 1'b0}) begin
                failures++;
                $display("FAIL w6_emit%0d {sv,so,cv}: got %b expected %b", k,
                         {d_ser_valid, d_ser_out, d_crc_valid}, {1'b1, exp[5-k], 1'b0});
            end
            tick();
        end
        checks++;
        if ({d_ser_valid, d_crc_valid, d_match} !== 3'b010) begin
            failures++;
            $display("FAIL w6_done {sv,cv,match}: got %b expected 010", {d_ser_valid, d_crc_valid, d_match});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_single_bit();
        test_restart_gaps();
        test_start_ignored();
        test_reset_mid();
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
